// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: time-multiplexes one single-ported, fixed-latency memory
// between the instruction-fetch and data-memory requesters. Each access holds
// the memory for MEM_LAT cycles, then returns a registered ack pulse and read
// data. Ties between the two requesters are broken round-robin.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    // instruction-fetch requester
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    output logic              if_stall,
    // data-memory requester
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ack,
    output logic              dm_stall,
    // memory macro side
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    // debug
    output logic [1:0]        grant_state
);

    localparam int                CNT_W    = $clog2(MEM_LAT) + 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_SERVE_I = 2'b01,
        ST_SERVE_D = 2'b10
    } state_e;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_e;

    if (MEM_LAT < 1) begin : g_bad_lat
        $error("mem_port_arbiter: MEM_LAT must be at least 1");
    end

    state_e              state_q,      state_d;
    logic [CNT_W-1:0]    cnt_q,        cnt_d;
    grant_e              last_grant_q, last_grant_d;
    logic                if_ack_q,     if_ack_d;
    logic                dm_ack_q,     dm_ack_d;
    logic [DATA_W-1:0]   if_rdata_q,   if_rdata_d;
    logic [DATA_W-1:0]   dm_rdata_q,   dm_rdata_d;
    logic [ADDR_W-1:0]   addr_q,       addr_d;
    logic [DATA_W-1:0]   wdata_q,      wdata_d;
    logic                we_q,         we_d;

    logic                i_elig;
    logic                d_elig;
    logic                last_beat;

    // A requester whose ack is showing this cycle has just been served and
    // must not be granted again until it re-presents its request.
    always_comb begin
        i_elig    = if_req & ~if_ack_q;
        d_elig    = dm_req & ~dm_ack_q;
        last_beat = (cnt_q == CNT_LAST);
    end

    // Next-state, arbitration, access sequencing and completion capture.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        if_ack_d     = 1'b0;
        dm_ack_d     = 1'b0;
        if_rdata_d   = if_rdata_q;
        dm_rdata_d   = dm_rdata_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        we_d         = we_q;

        case (state_q)
            ST_IDLE: begin
                if (d_elig && (!i_elig || (last_grant_q == GRANT_I))) begin
                    state_d      = ST_SERVE_D;
                    cnt_d        = '0;
                    last_grant_d = GRANT_D;
                    addr_d       = dm_addr;
                    wdata_d      = dm_wdata;
                    we_d         = dm_we;
                end else if (i_elig) begin
                    state_d      = ST_SERVE_I;
                    cnt_d        = '0;
                    last_grant_d = GRANT_I;
                    addr_d       = if_addr;
                    we_d         = 1'b0;
                end
            end

            ST_SERVE_I: begin
                if (last_beat) begin
                    state_d    = ST_IDLE;
                    cnt_d      = '0;
                    if_rdata_d = mem_rdata;
                    if_ack_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_SERVE_D: begin
                if (last_beat) begin
                    state_d  = ST_IDLE;
                    cnt_d    = '0;
                    dm_ack_d = 1'b1;
                    if (!we_q) begin
                        dm_rdata_d = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            last_grant_q <= GRANT_I;
            if_ack_q     <= 1'b0;
            dm_ack_q     <= 1'b0;
            if_rdata_q   <= '0;
            dm_rdata_q   <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            if_ack_q     <= if_ack_d;
            dm_ack_q     <= dm_ack_d;
            if_rdata_q   <= if_rdata_d;
            dm_rdata_q   <= dm_rdata_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            we_q         <= we_d;
        end
    end

    // Memory strobes: the write strobe fires only on the final beat so a
    // store commits exactly once and an aborted store never reaches memory.
    always_comb begin
        mem_en    = (state_q != ST_IDLE);
        mem_we    = mem_en & we_q & last_beat;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
    end

    // Requester-facing outputs; stalls are combinational from req and the
    // registered ack.
    always_comb begin
        if_ack      = if_ack_q;
        dm_ack      = dm_ack_q;
        if_rdata    = if_rdata_q;
        dm_rdata    = dm_rdata_q;
        if_stall    = if_req & ~if_ack_q;
        dm_stall    = dm_req & ~dm_ack_q;
        grant_state = state_q;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboarded bench for mem_port_arbiter: instance A uses MEM_LAT=2,
// instance B uses MEM_LAT=1. Stimulus pushes expected acks (cycle + data)
// into queues; a monitor pops them whenever an ack is presented.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    // instance A signals (MEM_LAT=2)
    logic        a_if_req, a_if_ack, a_if_stall;
    logic [31:0] a_if_addr, a_if_rdata;
    logic        a_dm_req, a_dm_we, a_dm_ack, a_dm_stall;
    logic [31:0] a_dm_addr, a_dm_wdata, a_dm_rdata;
    logic        a_mem_en, a_mem_we;
    logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;
    logic [1:0]  a_grant_state;

    // instance B signals (MEM_LAT=1)
    logic        b_if_req, b_if_ack, b_if_stall;
    logic [31:0] b_if_addr, b_if_rdata;
    logic        b_dm_req, b_dm_we, b_dm_ack, b_dm_stall;
    logic [31:0] b_dm_addr, b_dm_wdata, b_dm_rdata;
    logic        b_mem_en, b_mem_we;
    logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic [1:0]  b_grant_state;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) u_dut_a (
        .clk(clk), .reset(reset),
        .if_req(a_if_req), .if_addr(a_if_addr), .if_rdata(a_if_rdata),
        .if_ack(a_if_ack), .if_stall(a_if_stall),
        .dm_req(a_dm_req), .dm_we(a_dm_we), .dm_addr(a_dm_addr),
        .dm_wdata(a_dm_wdata), .dm_rdata(a_dm_rdata), .dm_ack(a_dm_ack),
        .dm_stall(a_dm_stall),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata),
        .grant_state(a_grant_state)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_dut_b (
        .clk(clk), .reset(reset),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata),
        .if_ack(b_if_ack), .if_stall(b_if_stall),
        .dm_req(b_dm_req), .dm_we(b_dm_we), .dm_addr(b_dm_addr),
        .dm_wdata(b_dm_wdata), .dm_rdata(b_dm_rdata), .dm_ack(b_dm_ack),
        .dm_stall(b_dm_stall),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata),
        .grant_state(b_grant_state)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Preloaded memory image: word index -> contents.
    function automatic logic [31:0] init_word(input logic [7:0] idx);
        case (idx)
            8'd0:    return 32'h0000_0013;
            8'd1:    return 32'h0040_0093;
            8'd4:    return 32'hDEAD_BEEF;
            default: return ({24'h0, idx} * 32'h0101_0101) ^ 32'h5A00_0000;
        endcase
    endfunction

    // Memory model for A: written words override the preload image.
    bit [31:0] mem_a [256];
    bit        wr_a  [256];
    logic [7:0] a_idx;

    always_comb begin
        a_idx       = a_mem_addr[9:2];
        a_mem_rdata = wr_a[a_idx] ? mem_a[a_idx] : init_word(a_idx);
    end

    always @(posedge clk) begin
        if (a_mem_en && a_mem_we) begin
            mem_a[a_mem_addr[9:2]] <= a_mem_wdata;
            wr_a[a_mem_addr[9:2]]  <= 1'b1;
        end
    end

    // Memory model for B: read-only preload image.
    always_comb b_mem_rdata = init_word(b_mem_addr[9:2]);

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } exp_t;

    exp_t q_a_if[$];
    exp_t q_a_dm[$];
    exp_t q_b_if[$];
    exp_t q_b_dm[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: ack seen at cycle %0d, none expected", name, cyc);
    endtask

    // Monitor: every ack pops one expected entry and checks cycle and data.
    always @(negedge clk) begin
        exp_t e;
        if (a_dm_ack === 1'b1) begin
            if (q_a_dm.size() == 0) unexpected("a_dm_ack");
            else begin
                e = q_a_dm.pop_front();
                check("a_dm_ack_cycle", cyc, e.cyc);
                check("a_dm_rdata", a_dm_rdata, e.data);
            end
        end
        if (a_if_ack === 1'b1) begin
            if (q_a_if.size() == 0) unexpected("a_if_ack");
            else begin
                e = q_a_if.pop_front();
                check("a_if_ack_cycle", cyc, e.cyc);
                check("a_if_rdata", a_if_rdata, e.data);
            end
        end
        if (b_if_ack === 1'b1) begin
            if (q_b_if.size() == 0) unexpected("b_if_ack");
            else begin
                e = q_b_if.pop_front();
                check("b_if_ack_cycle", cyc, e.cyc);
                check("b_if_rdata", b_if_rdata, e.data);
            end
        end
        if (b_dm_ack === 1'b1) begin
            if (q_b_dm.size() == 0) unexpected("b_dm_ack");
            else e = q_b_dm.pop_front();
        end
    end

    task automatic push_exp(input bit is_b, input bit is_dm, input int c, input logic [31:0] d);
        exp_t e;
        e.cyc  = c;
        e.data = d;
        if (!is_b && is_dm)  q_a_dm.push_back(e);
        if (!is_b && !is_dm) q_a_if.push_back(e);
        if (is_b && !is_dm)  q_b_if.push_back(e);
        if (is_b && is_dm)   q_b_dm.push_back(e);
    endtask

    task automatic idle_inputs();
        a_if_req = 1'b0; a_if_addr = '0;
        a_dm_req = 1'b0; a_dm_we = 1'b0; a_dm_addr = '0; a_dm_wdata = '0;
        b_if_req = 1'b0; b_if_addr = '0;
        b_dm_req = 1'b0; b_dm_we = 1'b0; b_dm_addr = '0; b_dm_wdata = '0;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        reset = 1'b1;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Lone data access on A: req at cycle 0, service cycles 1-2, ack cycle 3.
    task automatic dm_access(input string tag, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] exp_rd);
        int t0;
        @(negedge clk);
        t0 = cyc;
        a_dm_req = 1'b1; a_dm_we = we; a_dm_addr = addr; a_dm_wdata = wdata;
        push_exp(1'b0, 1'b1, t0 + 3, exp_rd);
        #1 check({tag, "_stall_c0"}, 32'(a_dm_stall), 32'd1);
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            check({tag, "_stall"}, 32'(a_dm_stall), 32'd1);
            check({tag, "_mem_en"}, 32'(a_mem_en), 32'd1);
            check({tag, "_mem_addr"}, a_mem_addr, addr);
            check({tag, "_mem_we"}, 32'(a_mem_we), 32'((k == 2) && we));
            check({tag, "_grant"}, 32'(a_grant_state), 32'd2);
            if (we && k == 2) check({tag, "_mem_wdata"}, a_mem_wdata, wdata);
        end
        @(negedge clk);
        check({tag, "_stall_ack"}, 32'(a_dm_stall), 32'd0);
        check({tag, "_mem_en_ack"}, 32'(a_mem_en), 32'd0);
        a_dm_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        logic [31:0] b_exp [4];
        b_exp[0] = 32'h0000_0013;
        b_exp[1] = 32'h0040_0093;
        b_exp[2] = 32'h5802_0202;
        b_exp[3] = 32'h5903_0303;

        reset = 1'b1;
        idle_inputs();
        reset_dut();

        // reset state
        check("rst_grant", 32'(a_grant_state), 32'd0);
        check("rst_mem_en", 32'(a_mem_en), 32'd0);
        check("rst_mem_we", 32'(a_mem_we), 32'd0);
        check("rst_if_ack", 32'(a_if_ack), 32'd0);
        check("rst_dm_ack", 32'(a_dm_ack), 32'd0);
        check("rst_if_rdata", a_if_rdata, 32'd0);
        check("rst_dm_rdata", a_dm_rdata, 32'd0);
        check("rst_mem_addr", a_mem_addr, 32'd0);
        check("rst_mem_wdata", a_mem_wdata, 32'd0);
        check("rst_b_grant", 32'(b_grant_state), 32'd0);

        // lone load
        dm_access("t1_load", 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF);

        // store leaves dm_rdata alone, then load sees the stored word
        dm_access("t6_store", 1'b1, 32'h40, 32'hA5A5_A5A5, 32'hDEAD_BEEF);
        dm_access("t6_load", 1'b0, 32'h40, 32'h0, 32'hA5A5_A5A5);

        // simultaneous requests right after reset: D wins the first tie
        reset_dut();
        @(negedge clk);
        t0 = cyc;
        a_if_req = 1'b1; a_if_addr = 32'h0;
        a_dm_req = 1'b1; a_dm_we = 1'b1; a_dm_addr = 32'h20; a_dm_wdata = 32'h1234_5678;
        push_exp(1'b0, 1'b1, t0 + 3, 32'h0);
        push_exp(1'b0, 1'b0, t0 + 6, 32'h0000_0013);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            check("t2_mem_we", 32'(a_mem_we), 32'(k == 2));
            check("t2_if_stall", 32'(a_if_stall), 32'(k != 6));
            if (k == 1) begin
                check("t2_grant_d", 32'(a_grant_state), 32'd2);
                check("t2_addr_d", a_mem_addr, 32'h20);
            end
            if (k == 4) begin
                check("t2_grant_i", 32'(a_grant_state), 32'd1);
                check("t2_addr_i", a_mem_addr, 32'h0);
            end
            if (k == 3) begin
                check("t2_dm_stall_ack", 32'(a_dm_stall), 32'd0);
                a_dm_req = 1'b0;
            end
            if (k == 6) a_if_req = 1'b0;
        end
        check("t2_mem_written_flag", 32'(wr_a[8]), 32'd1);
        check("t2_mem_written_data", mem_a[8], 32'h1234_5678);

        // both requesters held: grants alternate D, I, D, I every 3 cycles
        reset_dut();
        @(negedge clk);
        t0 = cyc;
        a_if_req = 1'b1; a_if_addr = 32'h4;
        a_dm_req = 1'b1; a_dm_we = 1'b0; a_dm_addr = 32'h10;
        push_exp(1'b0, 1'b1, t0 + 3,  32'hDEAD_BEEF);
        push_exp(1'b0, 1'b1, t0 + 9,  32'hDEAD_BEEF);
        push_exp(1'b0, 1'b0, t0 + 6,  32'h0040_0093);
        push_exp(1'b0, 1'b0, t0 + 12, 32'h0040_0093);
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            if (k == 1 || k == 7)  check("t3_grant_d", 32'(a_grant_state), 32'd2);
            if (k == 4 || k == 10) check("t3_grant_i", 32'(a_grant_state), 32'd1);
            if (k == 13)           check("t3_grant_idle", 32'(a_grant_state), 32'd0);
            if (k == 12) begin
                a_if_req = 1'b0;
                a_dm_req = 1'b0;
            end
        end

        // store aborted by reset while cnt=0: never written, no ack
        reset_dut();
        @(negedge clk);
        a_dm_req = 1'b1; a_dm_we = 1'b1; a_dm_addr = 32'h80; a_dm_wdata = 32'hCAFE_F00D;
        @(negedge clk);
        check("t4_grant_d", 32'(a_grant_state), 32'd2);
        check("t4_mem_we_c1", 32'(a_mem_we), 32'd0);
        reset = 1'b1;
        a_dm_req = 1'b0;
        @(negedge clk);
        check("t4_grant_idle", 32'(a_grant_state), 32'd0);
        check("t4_mem_en", 32'(a_mem_en), 32'd0);
        check("t4_mem_we_c2", 32'(a_mem_we), 32'd0);
        check("t4_dm_ack_c2", 32'(a_dm_ack), 32'd0);
        check("t4_mem_addr", a_mem_addr, 32'd0);
        check("t4_mem_wdata", a_mem_wdata, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("t4_mem_we_c3", 32'(a_mem_we), 32'd0);
        check("t4_dm_ack_c3", 32'(a_dm_ack), 32'd0);
        check("t4_not_written", 32'(wr_a[32]), 32'd0);

        // MEM_LAT=1 fetch stream; a lone requester is ineligible in its own
        // ack cycle, so fetches complete every MEM_LAT+2 = 3 cycles
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            t0 = cyc;
            check("t5_mem_en_idle", 32'(b_mem_en), 32'd0);
            b_if_req = 1'b1;
            b_if_addr = 32'(4 * i);
            push_exp(1'b1, 1'b0, t0 + 2, b_exp[i]);
            @(negedge clk);
            check("t5_mem_en_serve", 32'(b_mem_en), 32'd1);
            check("t5_mem_addr", b_mem_addr, 32'(4 * i));
            check("t5_grant_i", 32'(b_grant_state), 32'd1);
            @(negedge clk);
            check("t5_mem_en_ack", 32'(b_mem_en), 32'd0);
            check("t5_if_stall_ack", 32'(b_if_stall), 32'd0);
            b_if_req = 1'b0;
        end

        repeat (3) @(negedge clk);
        check("pending_a_if", 32'(q_a_if.size()), 32'd0);
        check("pending_a_dm", 32'(q_a_dm.size()), 32'd0);
        check("pending_b_if", 32'(q_b_if.size()), 32'd0);
        check("pending_b_dm", 32'(q_b_dm.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
